// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection controller: state codes and time constants.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GREEN   = 3'd1,
        YELLOW  = 3'd2,
        ALL_RED = 3'd3
    } state_t;

    localparam int MAX_TIME_W = 32;

    // All-ones value of the requested width, right-aligned in a MAX_TIME_W word.
    function automatic logic [MAX_TIME_W-1:0] time_all_ones(input int width);
        logic [MAX_TIME_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_TIME_W; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Three-flop synchroniser for an asynchronous push button with a one-cycle rising-edge pulse.
module button_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    // Shift chain: [0] and [1] resolve metastability, [2] remembers the previous level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
        end
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/manual_phase_ctrl.sv
// Manual-mode N-phase traffic-light controller: button advances GREEN -> YELLOW -> (ALL_RED) -> next GREEN.
// Optional all-red clearance is built when ALL_RED_CLEAR_EN is defined.
module manual_phase_ctrl
    import traffic_pkg::*;
#(
    parameter  int NUM_PHASES = 2,
    parameter  int TIME_W     = 7,
    localparam int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  buttonChangeLight,
    input  logic [TIME_W-1:0]     yellowTime,
    input  logic [TIME_W-1:0]     allRedTime,
    output logic [2:0]            state,
    output logic [PH_W-1:0]       activePhase,
    output logic [NUM_PHASES-1:0] greenMask,
    output logic [NUM_PHASES-1:0] yellowMask,
    output logic [TIME_W-1:0]     timeRemain
);

    localparam logic [TIME_W-1:0] TIME_ONES = TIME_W'(time_all_ones(TIME_W));
    localparam logic [TIME_W-1:0] TIME_ONE  = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(NUM_PHASES - 1);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [NUM_PHASES-1:0]   green_q, green_d;
    logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
    logic [TIME_W-1:0]       time_q, time_d;
    logic                    btn_edge_s;
    logic [PH_W-1:0]         next_phase_s;

    function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [PH_W-1:0] ph);
        logic [NUM_PHASES-1:0] m;
        m     = '0;
        m[ph] = 1'b1;
        return m;
    endfunction

    // A zero duration still gives one cycle in the timed state.
    function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] t);
        if (t == '0) begin
            return TIME_ONE;
        end else begin
            return t;
        end
    endfunction

    button_sync_edge u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (buttonChangeLight),
        .edge_o (btn_edge_s)
    );

    assign next_phase_s = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);

`ifndef ALL_RED_CLEAR_EN
    logic unused_all_red_s;
    assign unused_all_red_s = ^allRedTime;
`endif

    // Next-state and next-output logic; outputs are computed here so they register with the state.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        green_d  = green_q;
        yellow_d = yellow_q;
        time_d   = time_q;
        if (!enable) begin
            state_d  = IDLE;
            phase_d  = '0;
            green_d  = '0;
            yellow_d = '0;
            time_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = GREEN;
                    phase_d  = '0;
                    green_d  = phase_onehot('0);
                    yellow_d = '0;
                    time_d   = TIME_ONES;
                end
                GREEN: begin
                    if (btn_edge_s) begin
                        state_d  = YELLOW;
                        green_d  = '0;
                        yellow_d = phase_onehot(phase_q);
                        time_d   = at_least_one(yellowTime);
                    end else begin
                        green_d  = phase_onehot(phase_q);
                        yellow_d = '0;
                        time_d   = TIME_ONES;
                    end
                end
                YELLOW: begin
                    if (time_q <= TIME_ONE) begin
`ifdef ALL_RED_CLEAR_EN
                        state_d  = ALL_RED;
                        green_d  = '0;
                        yellow_d = '0;
                        time_d   = at_least_one(allRedTime);
`else
                        state_d  = GREEN;
                        phase_d  = next_phase_s;
                        green_d  = phase_onehot(next_phase_s);
                        yellow_d = '0;
                        time_d   = TIME_ONES;
`endif
                    end else begin
                        time_d = time_q - TIME_ONE;
                    end
                end
`ifdef ALL_RED_CLEAR_EN
                ALL_RED: begin
                    if (time_q <= TIME_ONE) begin
                        state_d  = GREEN;
                        phase_d  = next_phase_s;
                        green_d  = phase_onehot(next_phase_s);
                        yellow_d = '0;
                        time_d   = TIME_ONES;
                    end else begin
                        time_d = time_q - TIME_ONE;
                    end
                end
`endif
                default: begin
                    state_d  = IDLE;
                    phase_d  = '0;
                    green_d  = '0;
                    yellow_d = '0;
                    time_d   = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            time_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            time_q   <= time_d;
        end
    end

    assign state       = state_q;
    assign activePhase = phase_q;
    assign greenMask   = green_q;
    assign yellowMask  = yellow_q;
    assign timeRemain  = time_q;

endmodule

// File: doc/manual_phase_ctrl.md
# manual_phase_ctrl

Parametrised manual-mode traffic-light controller for the intersection controller. It generalises two-lane manual control to `NUM_PHASES` signal phases. An operator button press advances the held green phase through a timed yellow interval, an optional all-red clearance, and then on to the next phase in round-robin order. The block sits beside the automatic-mode timer and is selected by the top-level mode mux through `enable`.

## Interface
- `NUM_PHASES`, default 2: number of signal phases; must be ≥ 2.
- `TIME_W`, default 7: width of the time inputs and of the countdown output.
- `PH_W`, default `$clog2(NUM_PHASES)`: width of the phase index (derived, not overridden).

- `clk`  in  1: single system clock; one count per cycle.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: manual mode selected.
- `buttonChangeLight`  in  1: raw operator button, asynchronous to `clk`; synchronised internally.
- `yellowTime`  in  `TIME_W`: yellow duration in cycles; sampled on entry to YELLOW.
- `allRedTime`  in  `TIME_W`: clearance duration in cycles; sampled on entry to ALL_RED.
- `state`  out  3: current FSM state code.
- `activePhase`  out  `PH_W`: phase currently green, yellow, or just released.
- `greenMask`  out  `NUM_PHASES`: one-hot green per phase, or all zeros.
- `yellowMask`  out  `NUM_PHASES`: one-hot yellow per phase, or all zeros.
- `timeRemain`  out  `TIME_W`: remaining cycles in a timed state; all ones during GREEN.

Any phase not shown green or yellow is red.

## Operation
**States and codes:** IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3. All other codes are illegal and recover to IDLE on the next edge.

**Reset values:**
- `state`=IDLE, `activePhase`=0
- `greenMask`=0, `yellowMask`=0, `timeRemain`=0
- All synchroniser flops = 0

**IDLE:**
- All masks are 0 and `timeRemain`=0.
- When `enable`=1, go to GREEN with `activePhase`=0.

**GREEN:**
- `greenMask` has the bit for `activePhase` set; `timeRemain` is all ones.
- The state holds until a button press edge arrives.
- On the edge, go to YELLOW and load the counter with max(`yellowTime`,1).

**YELLOW:**
- `yellowMask` has the bit for `activePhase` set; `timeRemain` shows the counter.
- The counter decrements each cycle.
- When the counter is 1 at a clock edge:
  - With ALL_RED_CLEAR_EN defined: go to ALL_RED and load max(`allRedTime`,1).
  - Without it: go to GREEN and advance the phase.

**ALL_RED:**
- Both masks are 0; `timeRemain` shows the counter.
- When the counter is 1, go to GREEN and advance the phase.

**Phase advance:** `activePhase` ← `activePhase`+1, wrapping from `NUM_PHASES`-1 to 0.

**Button handling:**
- Two-flop synchroniser plus a third flop; edge = sync2 & ~sync3.
- The synchroniser runs always, including in IDLE and during reset release.
- Edges are acted on only in GREEN. Edges in YELLOW or ALL_RED are discarded, never queued.
- A held button produces exactly one edge.

**Enable and reset priority:**
- `enable`=0 in any state: go to IDLE on the next edge; the interval in progress is abandoned.
- `reset` has priority over `enable`.

## Timing
- **Button latency:** button first sampled high at edge n; the state shows YELLOW after edge n+2. The edge pulse fires in the cycle after n+1.
- **YELLOW length:** exactly Y cycles, where Y = max(`yellowTime`,1). `timeRemain` counts Y, Y-1, …, 1.
- **ALL_RED length:** exactly max(`allRedTime`,1) cycles.
- **Outputs:** all outputs are registered, so masks and `timeRemain` change on the same edge as `state`.
- **Input sampling:** time inputs are sampled only on the edge that enters a timed state. Changes mid-interval have no effect.
- **Enable:** a rising `enable` in IDLE gives GREEN with phase 0 after one edge.
- **Reset:** asserted mid-YELLOW, reset gives all reset values after that edge.

## Configuration
- **`ALL_RED_CLEAR_EN` defined:** the ALL_RED state and `allRedTime` are used between YELLOW and the next GREEN.
- **`ALL_RED_CLEAR_EN` not defined:**
  - The ALL_RED state is not implemented.
  - The `allRedTime` port remains but is ignored.
  - YELLOW goes directly to GREEN of the next phase.

## Structure
- **Package `traffic_pkg`:**
  - State code constants IDLE, GREEN, YELLOW, ALL_RED as a 3-bit typedef.
  - A function returning an all-ones time of width `TIME_W`.
- **Sub-module `button_sync_edge`:** the 3-flop synchroniser with a rising-edge pulse output. It takes `clk` and `reset` and is reusable by the automatic-mode pedestrian request.

## Test plan
- **Reset and enable:** reset, then `enable`=1 → after one edge: `state`=GREEN, `activePhase`=0, `greenMask`=01, `timeRemain`=7'h7F.
- **Yellow then advance, macro off:** press in GREEN with `yellowTime`=3 → YELLOW after 3 edges; `timeRemain` reads 3,2,1; then GREEN with `activePhase`=1, `greenMask`=10.
- **Clearance and wrap, macro on:** `NUM_PHASES`=3, `allRedTime`=2, start at phase 2 → press gives YELLOW, then ALL_RED for 2 cycles with masks 0, then GREEN with `activePhase`=0.
- **Ignored presses:** press during YELLOW, and button held for 20 cycles → exactly one phase advance; no extra YELLOW.
- **Zero times:** `yellowTime`=0 → YELLOW lasts exactly 1 cycle.
- **Disable mid-interval:** `enable` dropped mid-YELLOW → IDLE next edge, masks 0, `timeRemain`=0; re-enable gives GREEN on phase 0.
